// File: rtl/demux_1to8_seq.sv
// Serial-to-parallel 1-to-8 demux: rebuilds bytes from a bit stream, double-buffered.
// Define DEMUX_MSB_FIRST_EN to fill out[7] first and walk sel downward.
module demux_1to8_seq #(
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_bit,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       flush,
    output logic [2:0] sel,
    output logic [7:0] out,
    output logic       out_valid,
    input  logic       out_ready
);

    typedef enum logic {FILL, STALL} state_t;

`ifdef DEMUX_MSB_FIRST_EN
    localparam logic [2:0] FIRST = 3'd7;
    localparam logic [2:0] LAST  = 3'd0;
    localparam logic [2:0] STEP  = 3'd7;
`else
    localparam logic [2:0] FIRST = 3'd0;
    localparam logic [2:0] LAST  = 3'd7;
    localparam logic [2:0] STEP  = 3'd1;
`endif

    state_t     state, state_nxt;
    logic [2:0] sel_cnt, sel_nxt;
    logic [7:0] stage, stage_nxt;
    logic [7:0] merged;
    logic [7:0] out_nxt;
    logic       valid_nxt;

    assign in_ready = (state == FILL);
    assign sel      = sel_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            sel_cnt   <= FIRST;
            stage     <= '0;
            out       <= RESET_VAL;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            sel_cnt   <= sel_nxt;
            stage     <= stage_nxt;
            out       <= out_nxt;
            out_valid <= valid_nxt;
        end
    end

    // A drain clears out_valid unless a load in the same cycle re-asserts it.
    always_comb begin
        state_nxt        = state;
        sel_nxt          = sel_cnt;
        stage_nxt        = stage;
        out_nxt          = out;
        valid_nxt        = out_valid;
        merged           = stage;
        merged[sel_cnt]  = in_bit;

        if (out_valid && out_ready) begin
            valid_nxt = 1'b0;
        end

        if (flush) begin
            sel_nxt   = FIRST;
            stage_nxt = '0;
            state_nxt = FILL;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid) begin
                        stage_nxt = merged;
                        if (sel_cnt != LAST) begin
                            sel_nxt = sel_cnt + STEP;
                        end else if (!out_valid || out_ready) begin
                            out_nxt   = merged;
                            valid_nxt = 1'b1;
                            sel_nxt   = FIRST;
                        end else begin
                            sel_nxt   = FIRST;
                            state_nxt = STALL;
                        end
                    end
                end
                STALL: begin
                    // Completed frame waits in stage until the consumer frees out.
                    if (out_ready) begin
                        out_nxt   = stage;
                        valid_nxt = 1'b1;
                        state_nxt = FILL;
                    end
                end
                default: state_nxt = FILL;
            endcase
        end
    end

endmodule
